// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one LSB-first add cell stepped over WIDTH cycles.
// Define SERIAL_ADD_SUB_EN to add the sub port (a - b via inverted b and carry-in 1).
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Full-adder cell; returns {carry_out, sum_bit}.
  function automatic logic [1:0] add_cell(input logic x, input logic y, input logic c);
    logic p;
    p = x ^ y;
    return {(x & y) | (c & p), p ^ c};
  endfunction

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic [1:0]       w_cell;
  logic [WIDTH-1:0] w_b_load;
  logic             w_c_init;

  assign w_cell = add_cell(r_a[0], r_b[0], r_carry);

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction is a + ~b + 1, so only the b load and the initial carry differ.
  assign w_b_load = sub ? ~b : b;
  assign w_c_init = sub;
`else
  assign w_b_load = b;
  assign w_c_init = 1'b0;
`endif

  // Sequencer: state, operand/result shift registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= w_b_load;
            r_carry <= w_c_init;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        SHIFT: begin
          r_sum   <= {w_cell[0], r_sum[WIDTH-1:1]};
          r_a     <= {1'b0, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_carry <= w_cell[1];
          if (r_cnt == CNT_LAST) begin
            // Counter is left at its last value; the next start clears it.
            r_cout  <= w_cell[1];
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt   <= r_cnt + CNT_ONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign busy = r_busy;
  assign done = r_done;

endmodule
